// File: rtl/emu_pkg.sv
// Shared definitions for the co-emulation host sequencer and its wrappers.
// Holds the sequencer state encoding, the default array sizes that the
// wrappers and the sequencer must agree on, and a counter-width helper.
package emu_pkg;

  typedef enum logic [3:0] {
    ST_RX,    // accepting stimulus bytes from the host
    ST_WR,    // settle cycle so the wrapper latches the last stimulus byte
    ST_LOAD,  // load_emu strobe
    ST_CLKH,  // clk_dut held high
    ST_CLKL,  // clk_dut held low
    ST_GET,   // get_emu strobe
    ST_RA,    // present read address to the wrapper
    ST_RC,    // capture wrapper read data
    ST_TX     // offer captured byte to the host
  } emu_state_t;

  localparam int EMU_NUM_STIM = 2;
  localparam int EMU_NUM_OUT  = 4;
  localparam int EMU_ADDR_W   = 3;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/emu_host_sequencer_if.sv
// Emulation port bundle between the host sequencer and the host link /
// wrapper side.
//   rx_*      : host -> sequencer stimulus byte stream (valid/ready)
//   tx_*      : sequencer -> host output byte stream (valid/ready)
//   Din_emu, Addr_emu, load_emu, get_emu, clk_dut : drive the wrapper
//   Dout_emu  : registered read data from the wrapper
//   busy      : sequencer is not accepting stimulus
// master = sequencer side, slave = host link + wrapper side.
interface emu_host_sequencer_if
  import emu_pkg::*;
#(
  parameter int ADDR_W = EMU_ADDR_W
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        Din_emu;
  logic [ADDR_W-1:0] Addr_emu;
  logic              load_emu;
  logic              get_emu;
  logic              clk_dut;
  logic [7:0]        Dout_emu;
  logic              busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, Dout_emu,
    output rx_ready, tx_data, tx_valid, Din_emu, Addr_emu,
           load_emu, get_emu, clk_dut, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, Dout_emu,
    input  rx_ready, tx_data, tx_valid, Din_emu, Addr_emu,
           load_emu, get_emu, clk_dut, busy
  );

endinterface

// File: rtl/emu_host_sequencer.sv
// Host-side transactor for the co-emulation port. Collects NUM_STIM bytes
// from the host into the wrapper stimulus array, strobes load_emu, runs one
// clk_dut cycle, strobes get_emu, then reads NUM_OUT bytes back and streams
// them to the host.
// Ports: clk_emu (single clock), reset (async, active high),
//        bus (emu_host_sequencer_if.master, see interface for signals).
// All outputs come straight from registers.
//
// state | meaning
// RX    | rx_ready=1, write each received byte to stimIn[si]
// WR    | hold last write one cycle so the wrapper latches it
// LOAD  | load_emu=1 for one cycle
// CLKH  | clk_dut=1 for CLK_HIGH cycles
// CLKL  | clk_dut=0 for CLK_LOW cycles
// GET   | get_emu=1 for one cycle, oi cleared
// RA    | Addr_emu=oi, wrapper registers Dout_emu
// RC    | capture Dout_emu into tx_data, raise tx_valid
// TX    | wait for tx_ready, then next byte or back to RX
module emu_host_sequencer
  import emu_pkg::*;
#(
  parameter int NUM_STIM = EMU_NUM_STIM,
  parameter int NUM_OUT  = EMU_NUM_OUT,
  parameter int ADDR_W   = EMU_ADDR_W,
  parameter int CLK_HIGH = 2,
  parameter int CLK_LOW  = 2
) (
  input logic                  clk_emu,
  input logic                  reset,
  emu_host_sequencer_if.master bus
);

  localparam int SI_W = cnt_w(NUM_STIM);
  localparam int OI_W = cnt_w(NUM_OUT);
  localparam int PH_W = cnt_w((CLK_HIGH > CLK_LOW) ? CLK_HIGH : CLK_LOW);

  emu_state_t        r_state;
  logic [SI_W-1:0]   r_si;
  logic [OI_W-1:0]   r_oi;
  logic [PH_W-1:0]   r_ph;
  logic              r_rx_ready;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic [7:0]        r_din;
  logic [ADDR_W-1:0] r_addr;
  logic              r_load;
  logic              r_get;
  logic              r_clk_dut;
  logic              r_busy;

  logic w_rx_fire;
  logic w_tx_fire;

  assign w_rx_fire = bus.rx_valid & r_rx_ready;
  assign w_tx_fire = bus.tx_ready & r_tx_valid;

  always_ff @(posedge clk_emu or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RX;
      r_si       <= '0;
      r_oi       <= '0;
      r_ph       <= '0;
      r_rx_ready <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_din      <= '0;
      r_addr     <= '0;
      r_load     <= 1'b0;
      r_get      <= 1'b0;
      r_clk_dut  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_RX: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            r_din  <= bus.rx_data;
            r_addr <= ADDR_W'(r_si);
            if (r_si == SI_W'(NUM_STIM - 1)) begin
              r_si       <= '0;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= ST_WR;
            end else begin
              r_si <= r_si + SI_W'(1);
            end
          end
        end
        ST_WR: begin
          r_load  <= 1'b1;
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_load    <= 1'b0;
          r_clk_dut <= 1'b1;
          r_ph      <= PH_W'(CLK_HIGH - 1);
          r_state   <= ST_CLKH;
        end
        ST_CLKH: begin
          if (r_ph == '0) begin
            r_clk_dut <= 1'b0;
            r_ph      <= PH_W'(CLK_LOW - 1);
            r_state   <= ST_CLKL;
          end else begin
            r_ph <= r_ph - PH_W'(1);
          end
        end
        ST_CLKL: begin
          if (r_ph == '0) begin
            r_get   <= 1'b1;
            r_oi    <= '0;
            r_state <= ST_GET;
          end else begin
            r_ph <= r_ph - PH_W'(1);
          end
        end
        ST_GET: begin
          r_get   <= 1'b0;
          r_addr  <= '0;
          r_din   <= '0;
          r_state <= ST_RA;
        end
        ST_RA: begin
          r_state <= ST_RC;
        end
        ST_RC: begin
          r_tx_data  <= bus.Dout_emu;
          r_tx_valid <= 1'b1;
          r_state    <= ST_TX;
        end
        ST_TX: begin
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            if (r_oi == OI_W'(NUM_OUT - 1)) begin
              r_si       <= '0;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_RX;
            end else begin
              // Address of the next byte must already be on the bus in RA.
              r_oi    <= r_oi + OI_W'(1);
              r_addr  <= ADDR_W'(r_oi + OI_W'(1));
              r_din   <= '0;
              r_state <= ST_RA;
            end
          end
        end
        default: r_state <= ST_RX;
      endcase
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.Din_emu  = r_din;
  assign bus.Addr_emu = r_addr;
  assign bus.load_emu = r_load;
  assign bus.get_emu  = r_get;
  assign bus.clk_dut  = r_clk_dut;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Bench for emu_host_sequencer: two instances (default parameters and a
// 5-stim/1-out/1-high/3-low variant), each with a small wrapper model.
// Expected stimulus and output bytes go into queues when a transaction is
// issued; negedge monitors pop and compare on load_emu and on tx transfers,
// and check strobe timing against hand-computed latencies.
module tb_emu_host_sequencer;
  import emu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  emu_host_sequencer_if #(.ADDR_W(EMU_ADDR_W)) ifa ();
  emu_host_sequencer_if #(.ADDR_W(EMU_ADDR_W)) ifb ();

  emu_host_sequencer #(.NUM_STIM(2), .NUM_OUT(4), .ADDR_W(EMU_ADDR_W),
                       .CLK_HIGH(2), .CLK_LOW(2))
    dut_a (.clk_emu(clk), .reset(rst_a), .bus(ifa.master));

  emu_host_sequencer #(.NUM_STIM(5), .NUM_OUT(1), .ADDR_W(EMU_ADDR_W),
                       .CLK_HIGH(1), .CLK_LOW(3))
    dut_b (.clk_emu(clk), .reset(rst_b), .bus(ifb.master));

  // Wrapper model A: o0=s0&0F, o1=s1+69, o2=s0&s1, o3=~(s0&s1)
  logic [7:0] sa [0:7];
  logic [7:0] ca [0:7];
  logic [7:0] ra [0:3];
  logic [7:0] oa [0:3];
  logic       dq_a;
  always @(posedge clk) begin
    if (!ifa.load_emu && !ifa.get_emu) sa[ifa.Addr_emu] <= ifa.Din_emu;
    if (ifa.load_emu) ca <= sa;
    dq_a <= ifa.clk_dut;
    if (ifa.clk_dut && !dq_a) begin
      ra[0] <= ca[0] & 8'h0F;
      ra[1] <= ca[1] + 8'h69;
      ra[2] <= ca[0] & ca[1];
      ra[3] <= ~(ca[0] & ca[1]);
    end
    if (ifa.get_emu) oa <= ra;
    ifa.Dout_emu <= oa[ifa.Addr_emu[1:0]];
  end

  // Wrapper model B: single output = sum of five stimulus bytes
  logic [7:0] sb [0:7];
  logic [7:0] cb [0:7];
  logic [7:0] rb0, ob0;
  logic       dq_b;
  always @(posedge clk) begin
    if (!ifb.load_emu && !ifb.get_emu) sb[ifb.Addr_emu] <= ifb.Din_emu;
    if (ifb.load_emu) cb <= sb;
    dq_b <= ifb.clk_dut;
    if (ifb.clk_dut && !dq_b) rb0 <= cb[0] + cb[1] + cb[2] + cb[3] + cb[4];
    if (ifb.get_emu) ob0 <= rb0;
    ifb.Dout_emu <= (ifb.Addr_emu == 3'd0) ? ob0 : 8'h00;
  end

  logic [7:0] exp_stim_a[$], exp_tx_a[$];
  logic [7:0] exp_stim_b[$], exp_tx_b[$];

  // Monitor A
  int last_rx_a = 0, rxc_a = 0, hi_a = 0, fall_a = 0, rr_rise_a = 0, txn_a = 0;
  bit fp_a = 0, pv_a = 0, pr_a = 0, pclk_a = 0, prr_a = 0;
  logic [7:0] pd_a;
  logic [2:0] pa_a;
  always @(negedge clk) begin
    if (rst_a) begin
      rxc_a = 0; hi_a = 0; fp_a = 0; pv_a = 0; pclk_a = 0; prr_a = 0;
    end else begin
      if (ifa.rx_valid && ifa.busy) chk("rx_blocked_a", ifa.rx_ready, 0);
      if (ifa.rx_valid && ifa.rx_ready) begin rxc_a++; last_rx_a = cyc; end
      chk("excl_a", int'(ifa.load_emu) + int'(ifa.get_emu) + int'(ifa.clk_dut) > 1, 0);
      if (ifa.load_emu) begin
        chk("nwrites_a", rxc_a, 2);
        rxc_a = 0;
        chk("load_lat_a", cyc - last_rx_a, 2);
        chk("stim_q_a", exp_stim_a.size() >= 2, 1);
        for (int k = 0; k < 2; k++)
          if (exp_stim_a.size() > 0) chk("stim_a", sa[k], exp_stim_a.pop_front());
        fp_a = 1;
      end
      if (ifa.clk_dut) hi_a++;
      if (pclk_a && !ifa.clk_dut) begin
        chk("clk_high_a", hi_a, 2);
        hi_a = 0;
        fall_a = cyc;
      end
      if (ifa.get_emu) begin
        chk("get_gap_a", cyc - fall_a, 2);
        chk("get_lat_a", cyc - last_rx_a, 7);
      end
      if (ifa.tx_valid && !pv_a && fp_a) begin
        chk("tx_lat_a", cyc - last_rx_a, 10);
        fp_a = 0;
      end
      if (pv_a && !pr_a) begin
        chk("stall_valid_a", ifa.tx_valid, 1);
        chk("stall_data_a", ifa.tx_data, pd_a);
        chk("stall_addr_a", ifa.Addr_emu, pa_a);
      end
      if (ifa.tx_valid && ifa.tx_ready) begin
        txn_a++;
        chk("tx_q_a", exp_tx_a.size() > 0, 1);
        if (exp_tx_a.size() > 0) chk("tx_data_a", ifa.tx_data, exp_tx_a.pop_front());
      end
      if (ifa.rx_ready && !prr_a) rr_rise_a = cyc;
      pv_a = ifa.tx_valid; pr_a = ifa.tx_ready; pd_a = ifa.tx_data;
      pa_a = ifa.Addr_emu; pclk_a = ifa.clk_dut; prr_a = ifa.rx_ready;
    end
  end

  // Monitor B
  int last_rx_b = 0, rxc_b = 0, hi_b = 0, fall_b = 0;
  bit fp_b = 0, pv_b = 0, pr_b = 0, pclk_b = 0;
  logic [7:0] pd_b;
  logic [2:0] pa_b;
  always @(negedge clk) begin
    if (rst_b) begin
      rxc_b = 0; hi_b = 0; fp_b = 0; pv_b = 0; pclk_b = 0;
    end else begin
      if (ifb.rx_valid && ifb.busy) chk("rx_blocked_b", ifb.rx_ready, 0);
      if (ifb.rx_valid && ifb.rx_ready) begin rxc_b++; last_rx_b = cyc; end
      chk("excl_b", int'(ifb.load_emu) + int'(ifb.get_emu) + int'(ifb.clk_dut) > 1, 0);
      if (ifb.load_emu) begin
        chk("nwrites_b", rxc_b, 5);
        rxc_b = 0;
        chk("load_lat_b", cyc - last_rx_b, 2);
        chk("stim_q_b", exp_stim_b.size() >= 5, 1);
        for (int k = 0; k < 5; k++)
          if (exp_stim_b.size() > 0) chk("stim_b", sb[k], exp_stim_b.pop_front());
        fp_b = 1;
      end
      if (ifb.clk_dut) hi_b++;
      if (pclk_b && !ifb.clk_dut) begin
        chk("clk_high_b", hi_b, 1);
        hi_b = 0;
        fall_b = cyc;
      end
      if (ifb.get_emu) begin
        chk("get_gap_b", cyc - fall_b, 3);
        chk("get_lat_b", cyc - last_rx_b, 7);
      end
      if (ifb.tx_valid && !pv_b && fp_b) begin
        chk("tx_lat_b", cyc - last_rx_b, 10);
        fp_b = 0;
      end
      if (pv_b && !pr_b) begin
        chk("stall_data_b", ifb.tx_data, pd_b);
        chk("stall_addr_b", ifb.Addr_emu, pa_b);
      end
      if (ifb.tx_valid && ifb.tx_ready) begin
        chk("tx_q_b", exp_tx_b.size() > 0, 1);
        if (exp_tx_b.size() > 0) chk("tx_data_b", ifb.tx_data, exp_tx_b.pop_front());
      end
      pv_b = ifb.tx_valid; pr_b = ifb.tx_ready; pd_b = ifb.tx_data;
      pa_b = ifb.Addr_emu; pclk_b = ifb.clk_dut;
    end
  end

  task automatic drive_rx(input bit b, input logic v, input logic [7:0] d);
    if (b) begin ifb.rx_valid = v; ifb.rx_data = d; end
    else   begin ifa.rx_valid = v; ifa.rx_data = d; end
  endtask

  function automatic logic rxr(input bit b);
    return b ? ifb.rx_ready : ifa.rx_ready;
  endfunction

  function automatic logic bsy(input bit b);
    return b ? ifb.busy : ifa.busy;
  endfunction

  function automatic int txq(input bit b);
    return b ? exp_tx_b.size() : exp_tx_a.size();
  endfunction

  task automatic send_byte(input bit b, input logic [7:0] d, input int idle);
    int t;
    drive_rx(b, 1'b1, d);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rxr(b)) break;
    end
    chk("rx_accept", t < 200, 1);
    @(posedge clk); #1;
    drive_rx(b, 1'b0, 8'h00);
    if (idle > 0) begin
      repeat (idle) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input bit b);
    int t;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!bsy(b) && rxr(b) && txq(b) == 0) break;
    end
    chk("txn_done", t < 400, 1);
    @(posedge clk); #1;
  endtask

  task automatic txn_a_full(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] o0, input logic [7:0] o1,
                            input logic [7:0] o2, input logic [7:0] o3);
    exp_stim_a.push_back(s0); exp_stim_a.push_back(s1);
    exp_tx_a.push_back(o0); exp_tx_a.push_back(o1);
    exp_tx_a.push_back(o2); exp_tx_a.push_back(o3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base;
    logic [7:0] vb [0:4];
    ifa.rx_valid = 0; ifa.rx_data = 0; ifa.tx_ready = 1;
    ifb.rx_valid = 0; ifb.rx_data = 0; ifb.tx_ready = 1;
    rst_a = 1; rst_b = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_a", {ifa.rx_ready, ifa.tx_data, ifa.tx_valid, ifa.Din_emu, ifa.Addr_emu,
                      ifa.load_emu, ifa.get_emu, ifa.clk_dut, ifa.busy}, 0);
    chk("rst_out_b", {ifb.rx_ready, ifb.tx_data, ifb.tx_valid, ifb.Din_emu, ifb.Addr_emu,
                      ifb.load_emu, ifb.get_emu, ifb.clk_dut, ifb.busy}, 0);
    rst_a = 0; rst_b = 0;
    @(posedge clk); #1;
    chk("rx_ready_post_rst_a", ifa.rx_ready, 1);
    chk("busy_post_rst_a", ifa.busy, 0);
    chk("rx_ready_post_rst_b", ifb.rx_ready, 1);

    // Basic transaction and latency, tx_ready tied high
    txn_a_full(8'h21, 8'h5A, 8'h01, 8'hC3, 8'h00, 8'hFF);
    send_byte(0, 8'h21, 0);
    send_byte(0, 8'h5A, 0);
    wait_idle(0);
    chk("done_lat_a", rr_rise_a - last_rx_a, 20);

    // Backpressure: stall byte 2 for 7 cycles
    txn_a_full(8'h3C, 8'h96, 8'h0C, 8'hFF, 8'h14, 8'hEB);
    base = txn_a;
    send_byte(0, 8'h3C, 0);
    send_byte(0, 8'h96, 0);
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (txn_a == base + 2) break;
    end
    chk("bp_reach_byte2", t < 100, 1);
    @(posedge clk); #1;
    ifa.tx_ready = 0;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ifa.tx_valid) break;
    end
    chk("bp_valid_seen", t < 20, 1);
    repeat (7) @(posedge clk);
    #1;
    ifa.tx_ready = 1;
    wait_idle(0);
    chk("bp_byte_count", txn_a - base, 4);

    // Rx pacing plus a byte offered while busy
    txn_a_full(8'hF7, 8'h0E, 8'h07, 8'h77, 8'h06, 8'hF9);
    send_byte(0, 8'hF7, 5);
    send_byte(0, 8'h0E, 0);
    drive_rx(0, 1'b1, 8'hEE);
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ifa.get_emu) break;
    end
    chk("pace_get_seen", t < 50, 1);
    @(posedge clk); #1;
    drive_rx(0, 1'b0, 8'h00);
    wait_idle(0);

    // Reset while clk_dut is high
    exp_stim_a.push_back(8'hAA); exp_stim_a.push_back(8'h55);
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'h55, 0);
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ifa.clk_dut) break;
    end
    chk("clkh_seen", t < 50, 1);
    #2 rst_a = 1;
    #1;
    chk("rst_mid_out_a", {ifa.rx_ready, ifa.tx_data, ifa.tx_valid, ifa.Din_emu, ifa.Addr_emu,
                          ifa.load_emu, ifa.get_emu, ifa.clk_dut, ifa.busy}, 0);
    chk("rst_mid_clk_dut", ifa.clk_dut, 0);
    @(negedge clk);
    #2 rst_a = 0;
    @(posedge clk); #1;
    chk("rx_ready_post_mid_rst", ifa.rx_ready, 1);
    chk("busy_post_mid_rst", ifa.busy, 0);
    txn_a_full(8'h9B, 8'hE4, 8'h0B, 8'h4D, 8'h80, 8'h7F);
    send_byte(0, 8'h9B, 0);
    send_byte(0, 8'hE4, 0);
    wait_idle(0);

    // Parameter variant: 5 stim bytes, 1 output byte
    vb[0] = 8'h01; vb[1] = 8'h02; vb[2] = 8'h03; vb[3] = 8'h04; vb[4] = 8'h05;
    for (int k = 0; k < 5; k++) exp_stim_b.push_back(vb[k]);
    exp_tx_b.push_back(8'h0F);
    for (int k = 0; k < 5; k++) send_byte(1, vb[k], 0);
    wait_idle(1);
    vb[0] = 8'h80; vb[1] = 8'h40; vb[2] = 8'h20; vb[3] = 8'h10; vb[4] = 8'h08;
    for (int k = 0; k < 5; k++) exp_stim_b.push_back(vb[k]);
    exp_tx_b.push_back(8'hF8);
    for (int k = 0; k < 5; k++) send_byte(1, vb[k], 1);
    wait_idle(1);

    chk("stim_q_empty_a", exp_stim_a.size(), 0);
    chk("stim_q_empty_b", exp_stim_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/emu_host_sequencer.md
# emu_host_sequencer

Host-side transactor for the poor-man's co-emulation interface. It accepts stimulus bytes from a byte stream (UART/USB bridge side) and writes them into the wrapper's stimulus array. It then pulses `load_emu`, generates one `clk_dut` cycle, pulses `get_emu`, reads back the output vector and streams it out. It sits between the host link and any `*_wrapper` block, driving the wrapper's emulation port.

## Interface
- `NUM_STIM`, 2: stimulus bytes per transaction (wrapper `NUM_STIM_ARRAY`).
- `NUM_OUT`, 4: output bytes per transaction (wrapper `NUM_OUT_ARRAY`).
- `ADDR_W`, 3: width of `Addr_emu`.
- `CLK_HIGH`, 2: `clk_emu` cycles `clk_dut` is held high (≥1).
- `CLK_LOW`, 2: `clk_emu` cycles `clk_dut` is held low before `get_emu` (≥1).
- `clk_emu` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high.
- `rx_data` in 8: stimulus byte from host.
- `rx_valid` in 1 / `rx_ready` out 1: host→sequencer handshake; transfer on `rx_valid & rx_ready`.
- `tx_data` out 8: captured output byte to host.
- `tx_valid` out 1 / `tx_ready` in 1: sequencer→host handshake.
- `Din_emu` out 8, `Addr_emu` out `ADDR_W`: wrapper array write data/address.
- `load_emu` out 1, `get_emu` out 1: wrapper strobes.
- `clk_dut` out 1: controlled DUT clock.
- `Dout_emu` in 8: wrapper read data (registered inside the wrapper).
- `busy` out 1: high in every state except RX.

## Operation
- All outputs are registered. Reset values: every output is 0. After reset the sequencer enters RX, so `rx_ready` reads 1 from the first clock edge after reset is released.
- **RX**
  - `rx_ready=1`, stimulus index `si` starts at 0.
  - On each transfer: `Din_emu<=rx_data`, `Addr_emu<=si`, `si++`.
  - The wrapper latches `stimIn[Addr_emu]` on every cycle in which `load_emu=get_emu=0`.
  - When the transfer with `si==NUM_STIM-1` completes, go to WR.
- **WR**: one cycle, `rx_ready=0`, `Din_emu`/`Addr_emu` held. This guarantees the last byte is latched. Go to LOAD.
- **LOAD**: `load_emu=1` for exactly 1 cycle. Go to CLKH.
- **CLKH**: `clk_dut=1` for `CLK_HIGH` cycles. Go to CLKL.
- **CLKL**: `clk_dut=0` for `CLK_LOW` cycles. Go to GET.
- **GET**: `get_emu=1` for exactly 1 cycle. Output index `oi` is set to 0. Go to RA.
- **RA**: drive `Addr_emu<=oi` and `Din_emu<=0` for 1 cycle. The wrapper registers `Dout_emu` at the end of this cycle. Go to RC.
- **RC**: `tx_data<=Dout_emu`, `tx_valid<=1`. Go to TX.
- **TX**:
  - Hold `tx_data`/`tx_valid` until `tx_ready`.
  - On a transfer, drop `tx_valid`.
  - If `oi==NUM_OUT-1`, go to RX with `si=0`; otherwise `oi++` and go to RA.
- The wrapper keeps writing `stimIn[Addr_emu]<=Din_emu` during readout. This is harmless, because the next transaction rewrites every stimulus byte before LOAD.
- `load_emu`, `get_emu` and `clk_dut=1` are mutually exclusive in every cycle.
- `rx_valid` is ignored outside RX. `tx_valid` is never asserted outside RC/TX.

## Timing
- Last stimulus byte accepted in cycle T:
  - WR at T+1.
  - `load_emu` high at T+2.
  - `clk_dut` high over T+3 .. T+2+`CLK_HIGH`.
  - `get_emu` high at T+3+`CLK_HIGH`+`CLK_LOW`.
  - First `tx_valid` at T+6+`CLK_HIGH`+`CLK_LOW` (defaults: T+10).
- With `tx_ready` tied high, each output byte takes 3 cycles (RA, RC, TX).
- Back-to-back transactions: `rx_ready` rises in the cycle after the last tx transfer.
- Reset asserted mid-transaction (including CLKH): all outputs drop to 0 asynchronously, the state returns to RX, and `si` and `oi` clear. A truncated `clk_dut` pulse is acceptable; the host re-sends the transaction.
- Counter widths: `$clog2` of each bound, minimum 1 bit. Indices never exceed `NUM_STIM-1`/`NUM_OUT-1`. `Addr_emu` is zero-extended from the index.

## Structure
- Shared package `emu_pkg` holds:
  - the state enum (RX, WR, LOAD, CLKH, CLKL, GET, RA, RC, TX);
  - default `NUM_STIM`/`NUM_OUT`/`ADDR_W` constants, so wrappers and the sequencer agree.
- Single module, no sub-module. One FSM plus three counters: `si`, `oi`, and a shared phase counter for CLKH/CLKL.

## Test plan
- **Defaults, basic transaction.** Send 0x21, 0x5A with a wrapper model attached.
  - Writes: (Addr=0, Din=0x21) then (Addr=1, Din=0x5A).
  - `load_emu` pulses once.
  - `clk_dut` is high for exactly 2 cycles.
  - `get_emu` pulses once.
  - Model outputs 0x01, 0xC3, 0x00, 0xFF are returned in index order 0..3.
- **Latency.** With `tx_ready=1`:
  - first `tx_valid` exactly 10 cycles after the last rx transfer;
  - transaction done after 4×3 readout cycles.
- **Backpressure.** Hold `tx_ready=0` for 7 cycles on byte 2.
  - `tx_data` is stable and `tx_valid` stays high.
  - No `Addr_emu` change during the stall.
  - No duplicated or lost bytes.
- **Rx pacing.** Insert 5 idle cycles between stimulus bytes.
  - Only 2 writes occur.
  - `rx_ready` is low from WR until the transaction ends; bytes offered meanwhile are not consumed.
- **Reset mid-CLKH.** Assert `reset` while `clk_dut=1`.
  - All outputs are 0 in the same cycle.
  - After release the sequencer is in RX with `busy=0`, and a fresh transaction returns correct data.
- **Parameter sweep.** `NUM_STIM=5`, `NUM_OUT=1`, `CLK_HIGH=1`, `CLK_LOW=3`.
  - Addresses 0..4 are written.
  - One output byte is returned.
  - The `clk_dut` high width is 1 cycle and the high-to-`get_emu` gap is 3 cycles.
